// File: rtl/axi4_lite_reg_slave_if.sv
// AXI4-Lite channel bundle (AW/W/B/AR/R) shared by a bus master and a register responder.
// Clock and reset stay outside the bundle so each endpoint owns its own timing.
interface ifc_axi4_lite #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                      awvalid;
   logic                      awready;
   logic [ADDR_WIDTH-1:0]     awaddr;
   logic [2:0]                awprot;
   logic                      wvalid;
   logic                      wready;
   logic [DATA_WIDTH-1:0]     wdata;
   logic [DATA_WIDTH/8-1:0]   wstrb;
   logic                      bvalid;
   logic                      bready;
   logic [1:0]                bresp;
   logic                      arvalid;
   logic                      arready;
   logic [ADDR_WIDTH-1:0]     araddr;
   logic [2:0]                arprot;
   logic                      rvalid;
   logic                      rready;
   logic [DATA_WIDTH-1:0]     rdata;
   logic [1:0]                rresp;

   modport master (
      output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite register bank: independent write and read FSMs, byte strobes, read-only
// status registers and SLVERR on out-of-range or read-only writes.
module axi4_lite_reg_slave #(
   parameter int                      ADDR_WIDTH = 32,
   parameter int                      DATA_WIDTH = 32,
   parameter int                      N_REGS     = 16,
   parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = '0,
   parameter logic [DATA_WIDTH-1:0]   RESET_VAL  = '0,
   parameter logic [N_REGS-1:0]       RO_MASK    = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   ifc_axi4_lite.slave                  s_axi,
   input  logic [N_REGS*DATA_WIDTH-1:0] status_i,
   output logic [N_REGS*DATA_WIDTH-1:0] regs_o,
   output logic [N_REGS-1:0]            wr_pulse_o
);

   localparam int ADDR_LSB = $clog2(DATA_WIDTH/8);
   localparam int STRB_W   = DATA_WIDTH/8;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   generate
      if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_data_width
         $error("axi4_lite_reg_slave: DATA_WIDTH must be 32 or 64");
      end
      if (N_REGS < 1) begin : g_bad_n_regs
         $error("axi4_lite_reg_slave: N_REGS must be at least 1");
      end
   endgenerate

   typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_RESP} r_state_t;

   w_state_t                w_state;
   r_state_t                r_state;
   logic [ADDR_WIDTH-1:0]   aw_addr_q;
   logic [DATA_WIDTH-1:0]   w_data_q;
   logic [STRB_W-1:0]       w_strb_q;
   logic                    bvalid_q;
   logic [1:0]              bresp_q;
   logic                    rvalid_q;
   logic [1:0]              rresp_q;
   logic [DATA_WIDTH-1:0]   rdata_q;

   logic                    aw_hs;
   logic                    w_hs;
   logic                    commit;
   logic [ADDR_WIDTH-1:0]   c_addr;
   logic [DATA_WIDTH-1:0]   c_data;
   logic [STRB_W-1:0]       c_strb;
   logic [N_REGS-1:0]       wr_sel;
   logic [N_REGS-1:0]       wr_en;
   logic [N_REGS-1:0]       rd_sel;
   logic [DATA_WIDTH-1:0]   rd_data;

   // One-hot register select; all zero means the address falls outside the bank.
   function automatic logic [N_REGS-1:0] decode(input logic [ADDR_WIDTH-1:0] addr);
      logic [ADDR_WIDTH-1:0] idx;
      decode = '0;
      idx = (addr - BASE_ADDR) >> ADDR_LSB;
      for (int i = 0; i < N_REGS; i++) begin
         if (addr >= BASE_ADDR && idx == ADDR_WIDTH'(i)) begin
            decode[i] = 1'b1;
         end
      end
   endfunction

   assign s_axi.awready = !rst && (w_state == W_IDLE || w_state == W_HAVE_W);
   assign s_axi.wready  = !rst && (w_state == W_IDLE || w_state == W_HAVE_AW);
   assign s_axi.arready = !rst && (r_state == R_IDLE);
   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.bresp   = bresp_q;
   assign s_axi.rvalid  = rvalid_q;
   assign s_axi.rresp   = rresp_q;
   assign s_axi.rdata   = rdata_q;

   assign aw_hs = s_axi.awvalid && s_axi.awready;
   assign w_hs  = s_axi.wvalid && s_axi.wready;

   // The completing handshake supplies whichever half has not been latched yet.
   always_comb begin
      commit = 1'b0;
      c_addr = aw_addr_q;
      c_data = w_data_q;
      c_strb = w_strb_q;
      case (w_state)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               commit = 1'b1;
               c_addr = s_axi.awaddr;
               c_data = s_axi.wdata;
               c_strb = s_axi.wstrb;
            end
         end
         W_HAVE_AW: begin
            if (w_hs) begin
               commit = 1'b1;
               c_data = s_axi.wdata;
               c_strb = s_axi.wstrb;
            end
         end
         W_HAVE_W: begin
            if (aw_hs) begin
               commit = 1'b1;
               c_addr = s_axi.awaddr;
            end
         end
         default: ;
      endcase
   end

   assign wr_sel = decode(c_addr);
   assign wr_en  = wr_sel & ~RO_MASK;
   assign rd_sel = decode(s_axi.araddr);

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < N_REGS; i++) begin
         if (rd_sel[i]) begin
            rd_data = RO_MASK[i] ? status_i[i*DATA_WIDTH +: DATA_WIDTH]
                                 : regs_o[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Write path: register updates and the pulse land on the same edge that raises bvalid.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_state    <= W_IDLE;
         aw_addr_q  <= '0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         regs_o     <= {N_REGS{RESET_VAL}};
         wr_pulse_o <= '0;
      end else begin
         wr_pulse_o <= '0;
         if (commit) begin
            w_state    <= W_RESP;
            bvalid_q   <= 1'b1;
            bresp_q    <= (|wr_en) ? RESP_OKAY : RESP_SLVERR;
            wr_pulse_o <= wr_en;
            for (int i = 0; i < N_REGS; i++) begin
               for (int b = 0; b < STRB_W; b++) begin
                  if (wr_en[i] && c_strb[b]) begin
                     regs_o[i*DATA_WIDTH + b*8 +: 8] <= c_data[b*8 +: 8];
                  end
               end
            end
         end else begin
            case (w_state)
               W_IDLE: begin
                  if (aw_hs) begin
                     aw_addr_q <= s_axi.awaddr;
                     w_state   <= W_HAVE_AW;
                  end else if (w_hs) begin
                     w_data_q <= s_axi.wdata;
                     w_strb_q <= s_axi.wstrb;
                     w_state  <= W_HAVE_W;
                  end
               end
               W_RESP: begin
                  if (s_axi.bready) begin
                     bvalid_q <= 1'b0;
                     w_state  <= W_IDLE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Read path samples regs_o before any same-edge write commit takes effect.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= R_IDLE;
         rvalid_q <= 1'b0;
         rresp_q  <= RESP_OKAY;
         rdata_q  <= '0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (s_axi.arvalid) begin
                  rdata_q  <= rd_data;
                  rresp_q  <= (|rd_sel) ? RESP_OKAY : RESP_SLVERR;
                  rvalid_q <= 1'b1;
                  r_state  <= R_RESP;
               end
            end
            R_RESP: begin
               if (s_axi.rready) begin
                  rvalid_q <= 1'b0;
                  r_state  <= R_IDLE;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

endmodule
